// File: rtl/note_pkg.sv
// note_pkg
//   Shared definitions for the note tone generator and the ROM-content tooling.
//   - BASE_HALF: half-period length in clock cycles for each semitone in octave 0,
//     round(25e6 / f_octave0), valid for a 50 MHz system clock.
//   - NOTE_REST / NOTE_END: reserved note codes.
//   - Field positions of the packed 8-bit note code: [7]=rest, [6:4]=octave, [3:0]=semitone.
//   - state_t: tone generator state encoding.
package note_pkg;

  localparam int TABLE_CLK_HZ = 50_000_000;
  localparam int BASE_W       = 21;

  localparam logic [BASE_W-1:0] BASE_HALF [0:11] = '{
    21'd1528853, 21'd1443085, 21'd1362101, 21'd1285677,
    21'd1213474, 21'd1145370, 21'd1081081, 21'd1020408,
    21'd963132,  21'd909091,  21'd858074,  21'd809900
  };

  localparam logic [7:0] NOTE_REST = 8'h80;
  localparam logic [7:0] NOTE_END  = 8'hFF;

  localparam int REST_BIT = 7;
  localparam int OCT_HI   = 6;
  localparam int OCT_LO   = 4;
  localparam int SEM_HI   = 3;
  localparam int SEM_LO   = 0;
  localparam int NUM_SEMI = 12;

  typedef enum logic [1:0] {
    ST_SILENT = 2'd0,
    ST_TONE   = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

endpackage

// File: rtl/note_decode.sv
// note_decode
//   Combinational decode of one packed note code into a rest flag and the
//   half-period length of the corresponding square wave.
// Ports
//   code  in   8      packed note code
//   rest  out  1      1 when the code is a rest (rest flag set or semitone >= 12)
//   half  out  CNT_W  half-period in clock cycles, BASE_HALF[semitone] >> octave
module note_decode
  import note_pkg::*;
#(
  parameter int CNT_W = 21
) (
  input  logic [7:0]       code,
  output logic             rest,
  output logic [CNT_W-1:0] half
);

  logic [SEM_HI-SEM_LO:0] semitone;
  logic [OCT_HI-OCT_LO:0] octave;
  logic [BASE_W-1:0]      base_half;

  assign semitone = code[SEM_HI:SEM_LO];
  assign octave   = code[OCT_HI:OCT_LO];

  always_comb begin
    base_half = '0;
    if (int'(semitone) < NUM_SEMI) begin
      base_half = BASE_HALF[semitone];
    end
  end

  assign rest = code[REST_BIT] || (int'(semitone) >= NUM_SEMI);

  // Widen (or narrow) to the counter width first, then shift, so the result
  // truncates exactly like a CNT_W-bit logical right shift.
  assign half = CNT_W'(base_half) >> octave;

endmodule

// File: rtl/note_tone_gen.sv
// note_tone_gen
//   Turns the per-voice note code stream into a 50%-duty square wave.
//   Note changes are applied only on a half-period boundary so the output never
//   glitches; a repeated note on a beat tick is separated by a short silent gap.
// Ports
//   clock       in   1  system clock, rising edge
//   reset_n     in   1  asynchronous active-low reset
//   fullnote    in   8  note code: [7]=rest, [6:4]=octave, [3:0]=semitone
//   note_tick   in   1  one-cycle beat strobe
//   speaker     out  1  square-wave output
//   active      out  1  1 while a tone is sounding
//   note_start  out  1  one-cycle pulse when a tone starts or re-triggers
module note_tone_gen
  import note_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int GAP_CYCLES = 250_000,
  parameter int CNT_W      = 21
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] fullnote,
  input  logic       note_tick,
  output logic       speaker,
  output logic       active,
  output logic       note_start
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic PARAMS_OK = (CLK_HZ == TABLE_CLK_HZ) && (GAP_CYCLES >= 1);

  state_t           state_reg;
  logic [7:0]       req_code_reg;
  logic [7:0]       cur_code_reg;
  logic [CNT_W-1:0] cur_half_reg;
  logic [CNT_W-1:0] counter_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic             speaker_reg;
  logic             note_start_reg;

  logic             req_rest;
  logic [CNT_W-1:0] req_half;
  logic             half_done;
  logic             gap_done;
  logic             retrigger;

  note_decode #(.CNT_W(CNT_W)) u_decode (
    .code (req_code_reg),
    .rest (req_rest),
    .half (req_half)
  );

  assign half_done = (counter_reg == cur_half_reg - CNT_W'(1));
  assign gap_done  = (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1));
  assign retrigger = note_tick && (req_code_reg == cur_code_reg);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_SILENT;
      req_code_reg   <= NOTE_REST;
      cur_code_reg   <= NOTE_REST;
      cur_half_reg   <= '0;
      counter_reg    <= '0;
      gap_cnt_reg    <= '0;
      speaker_reg    <= 1'b0;
      note_start_reg <= 1'b0;
    end else begin
      req_code_reg   <= fullnote;
      note_start_reg <= 1'b0;

      case (state_reg)
        ST_SILENT: begin
          speaker_reg <= 1'b0;
          counter_reg <= '0;
          if (!req_rest) begin
            cur_code_reg   <= req_code_reg;
            cur_half_reg   <= req_half;
            speaker_reg    <= 1'b1;
            note_start_reg <= 1'b1;
            state_reg      <= ST_TONE;
          end
        end

        ST_TONE: begin
          // A re-trigger wins over a toggle landing on the same edge.
          if (retrigger) begin
            speaker_reg <= 1'b0;
            counter_reg <= '0;
            gap_cnt_reg <= '0;
            state_reg   <= ST_GAP;
          end else if (half_done) begin
            counter_reg <= '0;
            if (req_code_reg != cur_code_reg) begin
              if (req_rest) begin
                speaker_reg  <= 1'b0;
                cur_code_reg <= NOTE_REST;
                state_reg    <= ST_SILENT;
              end else begin
                cur_code_reg   <= req_code_reg;
                cur_half_reg   <= req_half;
                speaker_reg    <= 1'b1;
                note_start_reg <= 1'b1;
              end
            end else begin
              speaker_reg <= ~speaker_reg;
            end
          end else begin
            counter_reg <= counter_reg + CNT_W'(1);
          end
        end

        ST_GAP: begin
          speaker_reg <= 1'b0;
          counter_reg <= '0;
          if (gap_done) begin
            gap_cnt_reg <= '0;
            if (!req_rest) begin
              cur_code_reg   <= req_code_reg;
              cur_half_reg   <= req_half;
              speaker_reg    <= 1'b1;
              note_start_reg <= 1'b1;
              state_reg      <= ST_TONE;
            end else begin
              cur_code_reg <= NOTE_REST;
              state_reg    <= ST_SILENT;
            end
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
          end
        end

        default: begin
          speaker_reg <= 1'b0;
          counter_reg <= '0;
          state_reg   <= ST_SILENT;
        end
      endcase
    end
  end

  assign speaker    = speaker_reg;
  assign active     = (state_reg == ST_TONE);
  assign note_start = note_start_reg;

  // The decode table never yields a zero half-period; a zero would stall the wave.
  a_half_nonzero: assert property (@(posedge clock) disable iff (!reset_n)
    (state_reg == ST_TONE) |-> (cur_half_reg != '0));

  a_params_ok: assert property (@(posedge clock) PARAMS_OK);

endmodule

// File: tb/tb_note_tone_gen.sv
// tb_note_tone_gen
//   Directed bench for note_tone_gen. Octave-7 notes and a shortened gap keep
//   the run short while exercising the same paths as the octave-4 examples:
//     A7 (8'h79): 909091  >> 7 = 7102 cycles per half
//     C7 (8'h70): 1528853 >> 7 = 11944 cycles per half
module tb_note_tone_gen;

  localparam int GAP  = 1000;
  localparam int H_A7 = 7102;
  localparam int H_C7 = 11944;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] fullnote = 8'h49;
  logic       note_tick = 1'b0;
  logic       speaker;
  logic       active;
  logic       note_start;

  int vectors = 0;
  int errors  = 0;

  always #5 clock = ~clock;

  note_tone_gen #(
    .CLK_HZ     (50_000_000),
    .GAP_CYCLES (GAP),
    .CNT_W      (21)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .fullnote   (fullnote),
    .note_tick  (note_tick),
    .speaker    (speaker),
    .active     (active),
    .note_start (note_start)
  );

  // Advance one clock and land 1 ns after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Count cycles until speaker leaves 'level' (bounded by max).
  task automatic wait_speaker(input logic level, input int max, output int n, output logic ns);
    n = 0;
    do begin
      step();
      n++;
    end while (speaker === level && n < max);
    ns = note_start;
  endtask

  // Count cycles until note_start is seen (bounded by max).
  task automatic wait_start(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (note_start !== 1'b1 && n < max);
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    fullnote = 8'h49;
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if ({speaker, active, note_start} !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d spk/act/ns=%b required 000", i, {speaker, active, note_start});
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_tone();
    int   n;
    logic ns;
    fullnote = 8'h79;
    reset_n  = 1'b1;
    step();
    vectors++;
    if ({speaker, note_start} !== 2'b00) begin
      errors++;
      $display("FAIL tone_latency1 spk/ns=%b required 00", {speaker, note_start});
    end
    step();
    vectors++;
    if ({speaker, active, note_start} !== 3'b111) begin
      errors++;
      $display("FAIL tone_start spk/act/ns=%b required 111", {speaker, active, note_start});
    end
    step();
    vectors++;
    if (note_start !== 1'b0) begin
      errors++;
      $display("FAIL tone_start_width ns=%b required 0", note_start);
    end
    wait_speaker(1'b1, H_A7 + 100, n, ns);
    n = n + 1;
    vectors++;
    if (n != H_A7) begin
      errors++;
      $display("FAIL tone_half_high cycles=%0d required %0d", n, H_A7);
    end
    wait_speaker(1'b0, H_A7 + 100, n, ns);
    vectors++;
    if (n != H_A7) begin
      errors++;
      $display("FAIL tone_half_low cycles=%0d required %0d", n, H_A7);
    end
    $display("test_tone done half=%0d", n);
  endtask

  task automatic test_switch();
    int   n;
    logic ns;
    wait_speaker(1'b1, H_A7 + 100, n, ns);
    vectors++;
    if (n != H_A7) begin
      errors++;
      $display("FAIL switch_pre_half cycles=%0d required %0d", n, H_A7);
    end
    repeat (1000) step();
    fullnote = 8'h70;
    wait_speaker(1'b0, H_A7 + 100, n, ns);
    vectors++;
    if (n != H_A7 - 1000 || ns !== 1'b1) begin
      errors++;
      $display("FAIL switch_edge cycles=%0d ns=%b required %0d ns=1", n, ns, H_A7 - 1000);
    end
    wait_speaker(1'b1, H_C7 + 100, n, ns);
    vectors++;
    if (n != H_C7) begin
      errors++;
      $display("FAIL switch_new_half cycles=%0d required %0d", n, H_C7);
    end
    $display("test_switch done new_half=%0d", n);
  endtask

  task automatic test_rest();
    int   n;
    int   bad;
    logic ns;
    wait_speaker(1'b0, H_C7 + 100, n, ns);
    vectors++;
    if (n != H_C7) begin
      errors++;
      $display("FAIL rest_pre_half cycles=%0d required %0d", n, H_C7);
    end
    fullnote = 8'hFF;
    wait_speaker(1'b1, H_C7 + 100, n, ns);
    vectors++;
    if (n != H_C7 || active !== 1'b0) begin
      errors++;
      $display("FAIL rest_drop cycles=%0d act=%b required %0d act=0", n, active, H_C7);
    end
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (speaker !== 1'b0 || active !== 1'b0 || note_start !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rest_hold bad_cycles=%0d required 0", bad);
    end
    $display("test_rest done");
  endtask

  task automatic test_retrigger();
    int   n;
    int   bad;
    logic ns;
    fullnote = 8'h79;
    wait_start(10, n);
    vectors++;
    if (n != 2) begin
      errors++;
      $display("FAIL retrig_start cycles=%0d required 2", n);
    end
    repeat (100) step();
    note_tick = 1'b1;
    step();
    note_tick = 1'b0;
    vectors++;
    if ({speaker, active} !== 2'b00) begin
      errors++;
      $display("FAIL retrig_gap_entry spk/act=%b required 00", {speaker, active});
    end
    n   = 0;
    bad = 0;
    do begin
      if (n == 500) note_tick = 1'b1;
      if (n == 501) note_tick = 1'b0;
      step();
      n++;
      if (note_start !== 1'b1 && (speaker !== 1'b0 || active !== 1'b0)) bad++;
    end while (note_start !== 1'b1 && n < GAP + 100);
    vectors++;
    if (n != GAP || bad != 0) begin
      errors++;
      $display("FAIL retrig_gap_len cycles=%0d bad=%0d required %0d bad=0", n, bad, GAP);
    end
    vectors++;
    if ({speaker, active} !== 2'b11) begin
      errors++;
      $display("FAIL retrig_resume spk/act=%b required 11", {speaker, active});
    end
    wait_speaker(1'b1, H_A7 + 100, n, ns);
    vectors++;
    if (n != H_A7) begin
      errors++;
      $display("FAIL retrig_half cycles=%0d required %0d", n, H_A7);
    end
    $display("test_retrigger done");
  endtask

  task automatic test_invalid_and_async_reset();
    int n;
    int bad;
    fullnote = 8'h80;
    repeat (H_A7 + 10) step();
    vectors++;
    if ({speaker, active} !== 2'b00) begin
      errors++;
      $display("FAIL rest_code_silent spk/act=%b required 00", {speaker, active});
    end
    fullnote = 8'h4C;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (speaker !== 1'b0 || active !== 1'b0 || note_start !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL semitone12 bad_cycles=%0d required 0", bad);
    end
    fullnote = 8'h79;
    wait_start(10, n);
    vectors++;
    if (n != 2 || speaker !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre cycles=%0d spk=%b required 2 spk=1", n, speaker);
    end
    repeat (50) step();
    #3;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({speaker, active, note_start} !== 3'b000) begin
      errors++;
      $display("FAIL areset_async spk/act/ns=%b required 000", {speaker, active, note_start});
    end
    step();
    reset_n = 1'b1;
    wait_start(10, n);
    vectors++;
    if (n != 2 || speaker !== 1'b1) begin
      errors++;
      $display("FAIL areset_restart cycles=%0d spk=%b required 2 spk=1", n, speaker);
    end
    $display("test_invalid_and_async_reset done");
  endtask

  initial begin
    test_reset();
    test_tone();
    test_switch();
    test_rest();
    test_retrigger();
    test_invalid_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
